// File: rtl/axi_read_router.sv
// Read-side router: captures the granted master's AR request, forwards it to one slave and
// returns R beats through a single-entry register slice; unmapped reads get DECERR beats.
module axi_read_router #(
  parameter int unsigned NUM_S = 6,
  parameter int unsigned IDM   = 4,
  parameter int unsigned IDS   = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [3:0]           AR_arbiter,
  input  logic [IDM-1:0]       ARID_M0,
  input  logic [31:0]          ARADDR_M0,
  input  logic [3:0]           ARLEN_M0,
  input  logic [2:0]           ARSIZE_M0,
  input  logic [1:0]           ARBURST_M0,
  input  logic                 ARVALID_M0,
  output logic                 ARREADY_M0,
  input  logic [IDM-1:0]       ARID_M1,
  input  logic [31:0]          ARADDR_M1,
  input  logic [3:0]           ARLEN_M1,
  input  logic [2:0]           ARSIZE_M1,
  input  logic [1:0]           ARBURST_M1,
  input  logic                 ARVALID_M1,
  output logic                 ARREADY_M1,
  output logic [IDM-1:0]       RID_M0,
  output logic [31:0]          RDATA_M0,
  output logic [1:0]           RRESP_M0,
  output logic                 RLAST_M0,
  output logic                 RVALID_M0,
  input  logic                 RREADY_M0,
  output logic [IDM-1:0]       RID_M1,
  output logic [31:0]          RDATA_M1,
  output logic [1:0]           RRESP_M1,
  output logic                 RLAST_M1,
  output logic                 RVALID_M1,
  input  logic                 RREADY_M1,
  output logic [IDS-1:0]       ARID_S,
  output logic [31:0]          ARADDR_S,
  output logic [3:0]           ARLEN_S,
  output logic [2:0]           ARSIZE_S,
  output logic [1:0]           ARBURST_S,
  output logic [NUM_S-1:0]     ARVALID_S,
  input  logic [NUM_S-1:0]     ARREADY_S,
  input  logic [NUM_S*IDS-1:0] RID_S,
  input  logic [NUM_S*32-1:0]  RDATA_S,
  input  logic [NUM_S*2-1:0]   RRESP_S,
  input  logic [NUM_S-1:0]     RLAST_S,
  input  logic [NUM_S-1:0]     RVALID_S,
  output logic [NUM_S-1:0]     RREADY_S,
  output logic                 proto_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDerr} state_e;
  state_e state_q, state_d;

  logic [IDM-1:0] id_q;
  logic [31:0]    addr_q;
  logic [3:0]     len_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic           mst_q;
  logic [2:0]     tgt_q;
  logic           full_q;
  logic [IDS-1:0] sid_q;
  logic [31:0]    sdata_q;
  logic [1:0]     sresp_q;
  logic [3:0]     cnt_q;
  logic           perr_q;

  logic           gnt_mst, sel_arvalid, capture;
  logic [2:0]     gnt_tgt, sidx;
  logic           s_arready, s_rvalid, s_rlast, s_rready, load;
  logic [IDS-1:0] s_rid;
  logic [31:0]    s_rdata;
  logic [1:0]     s_rresp;
  logic           m_rready, m_rvalid, m_last, pop;
  logic [4:0]     ld_idx;
  logic [IDM-1:0] r_id;
  logic [31:0]    r_data;
  logic [1:0]     r_resp;

  assign gnt_mst     = AR_arbiter[0];
  assign gnt_tgt     = AR_arbiter[3:1];
  assign sel_arvalid = gnt_mst ? ARVALID_M1 : ARVALID_M0;
  assign capture     = (state_q == StIdle) && (gnt_tgt != 3'd0) && sel_arvalid;
  assign sidx        = tgt_q - 3'd1;

  always_comb begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    for (int unsigned i = 0; i < NUM_S; i++) begin
      if (sidx == i[2:0]) begin
        s_arready = ARREADY_S[i];
        s_rvalid  = RVALID_S[i];
        s_rlast   = RLAST_S[i];
        s_rid     = RID_S[i*IDS +: IDS];
        s_rdata   = RDATA_S[i*32 +: 32];
        s_rresp   = RRESP_S[i*2 +: 2];
      end
    end
  end

  assign m_rready = mst_q ? RREADY_M1 : RREADY_M0;
  assign m_rvalid = ((state_q == StData) && full_q) || (state_q == StDerr);
  assign m_last   = (cnt_q == len_q);
  assign pop      = m_rvalid && m_rready;
  // Index of the beat a slave load would carry; counts the beat still sitting in the slice.
  assign ld_idx   = {1'b0, cnt_q} + {4'd0, full_q};
  assign s_rready = (state_q == StData) && (!full_q || m_rready) && (ld_idx <= {1'b0, len_q});
  assign load     = s_rready && s_rvalid;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (capture) state_d = (gnt_tgt == 3'd7) ? StDerr : StAddr;
      StAddr: if (s_arready) state_d = StData;
      StData: if (pop && m_last) state_d = StIdle;
      StDerr: if (pop && m_last) state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      mst_q   <= 1'b0;
      tgt_q   <= '0;
      full_q  <= 1'b0;
      sid_q   <= '0;
      sdata_q <= '0;
      sresp_q <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      if (capture) begin
        mst_q   <= gnt_mst;
        tgt_q   <= gnt_tgt;
        id_q    <= gnt_mst ? ARID_M1    : ARID_M0;
        addr_q  <= gnt_mst ? ARADDR_M1  : ARADDR_M0;
        len_q   <= gnt_mst ? ARLEN_M1   : ARLEN_M0;
        size_q  <= gnt_mst ? ARSIZE_M1  : ARSIZE_M0;
        burst_q <= gnt_mst ? ARBURST_M1 : ARBURST_M0;
      end
      if (load) begin
        full_q  <= 1'b1;
        sid_q   <= s_rid;
        sdata_q <= s_rdata;
        sresp_q <= s_rresp;
      end else if (pop) begin
        full_q  <= 1'b0;
      end
      if (pop) cnt_q <= m_last ? 4'd0 : cnt_q + 4'd1;
      // The counter-derived last flag governs; a disagreeing slave RLAST is only recorded.
      if (load && (s_rlast != (ld_idx == {1'b0, len_q}))) perr_q <= 1'b1;
    end
  end

  assign r_id   = (state_q == StDerr) ? id_q  : sid_q[IDM-1:0];
  assign r_data = (state_q == StDerr) ? '0    : sdata_q;
  assign r_resp = (state_q == StDerr) ? 2'b11 : sresp_q;

  always_comb begin
    ARREADY_M0 = capture && !gnt_mst;
    ARREADY_M1 = capture && gnt_mst;
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    if (state_q == StAddr) begin
      ARID_S    = {(IDS-IDM)'(mst_q ? 2 : 1), id_q};
      ARADDR_S  = addr_q;
      ARLEN_S   = len_q;
      ARSIZE_S  = size_q;
      ARBURST_S = burst_q;
    end
    for (int unsigned i = 0; i < NUM_S; i++) begin
      ARVALID_S[i] = (state_q == StAddr) && (sidx == i[2:0]);
      RREADY_S[i]  = s_rready && (sidx == i[2:0]);
    end
    RVALID_M0 = 1'b0;
    RID_M0    = '0;
    RDATA_M0  = '0;
    RRESP_M0  = '0;
    RLAST_M0  = 1'b0;
    RVALID_M1 = 1'b0;
    RID_M1    = '0;
    RDATA_M1  = '0;
    RRESP_M1  = '0;
    RLAST_M1  = 1'b0;
    if (m_rvalid) begin
      if (mst_q) begin
        RVALID_M1 = 1'b1;
        RID_M1    = r_id;
        RDATA_M1  = r_data;
        RRESP_M1  = r_resp;
        RLAST_M1  = m_last;
      end else begin
        RVALID_M0 = 1'b1;
        RID_M0    = r_id;
        RDATA_M0  = r_data;
        RRESP_M0  = r_resp;
        RLAST_M0  = m_last;
      end
    end
  end

  assign proto_err = perr_q;

endmodule

// File: tb/tb_axi_read_router.sv
// Bench for axi_read_router: directed scenarios plus randomized traffic against a
// transaction-level model of slave beats and slice occupancy.
module tb_axi_read_router;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic [3:0] AR_arbiter;
  logic [3:0] ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1, RID_M0, RID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1, RDATA_M0, RDATA_M1;
  logic [2:0] ARSIZE_M0, ARSIZE_M1;
  logic [1:0] ARBURST_M0, ARBURST_M1, RRESP_M0, RRESP_M1;
  logic ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [7:0] ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0] ARLEN_S;
  logic [2:0] ARSIZE_S;
  logic [1:0] ARBURST_S;
  logic [5:0] ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
  logic [47:0] RID_S;
  logic [191:0] RDATA_S;
  logic [11:0] RRESP_S;
  logic proto_err;

  int checks = 0;
  int failures = 0;

  axi_read_router #(.NUM_S(6), .IDM(4), .IDS(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .AR_arbiter(AR_arbiter),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .proto_err(proto_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    AR_arbiter = '0;
    {ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARVALID_M0, RREADY_M0} = '0;
    {ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1, ARVALID_M1, RREADY_M1} = '0;
    {ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S} = '0;
  endtask

  // One complete read, modelled as: slave produces beats 0..len, master consumes them in
  // order, slice holds at most one beat and shows it the cycle after it is loaded.
  task automatic run_txn(input bit mst, input bit [2:0] tgt, input bit [3:0] len,
                         input int ar_stall, input int bad_beat, input bit use_pat,
                         input bit [15:0] rr_pat, input int abort_at, input bit [31:0] addr);
    bit [3:0] id;
    bit [2:0] sz;
    bit [1:0] bt;
    bit [31:0] data[17];
    bit [1:0] rsp[17];
    bit [5:0] exp_rs;
    int sidx, sp, mp, cyc;
    bit rr, rv, mv, ml, ov;
    bit [3:0] mi;
    bit [31:0] md;
    bit [1:0] mr;
    id = 4'($urandom); sz = 3'($urandom); bt = 2'($urandom);
    sidx = int'(tgt) - 1;
    for (int i = 0; i < 17; i++) begin
      data[i] = $urandom;
      rsp[i] = 2'($urandom_range(0, 1));
    end
    AR_arbiter = {tgt, mst};
    if (mst) begin
      {ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1} = {id, addr, len, sz, bt};
      ARVALID_M1 = 1'b1; ARVALID_M0 = 1'($urandom);
    end else begin
      {ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0} = {id, addr, len, sz, bt};
      ARVALID_M0 = 1'b1; ARVALID_M1 = 1'($urandom);
    end
    #1;
    checks++;
    if (ARREADY_M0 !== !mst || ARREADY_M1 !== mst) begin
      failures++;
      $display("FAIL ar_capture: ARREADY_M0=%b ARREADY_M1=%b required M%0d only",
               ARREADY_M0, ARREADY_M1, mst);
    end
    step();
    // Live grants from both masters must be ignored until the read completes.
    AR_arbiter = {3'($urandom_range(1, 7)), 1'($urandom)};
    ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
    if (tgt != 3'd7) begin
      for (int k = 0; k <= ar_stall; k++) begin
        ARREADY_S = (k == ar_stall) ? (6'b1 << sidx) : 6'b0;
        #1;
        checks++;
        if (ARVALID_S !== (6'b1 << sidx) || ARID_S !== {(mst ? 4'b0010 : 4'b0001), id} ||
            ARADDR_S !== addr || ARLEN_S !== len || ARSIZE_S !== sz || ARBURST_S !== bt ||
            ARREADY_M0 !== 1'b0 || ARREADY_M1 !== 1'b0) begin
          failures++;
          $display("FAIL ar_forward cyc%0d: ARVALID_S=%b ARID_S=%h ARADDR_S=%h ARLEN_S=%h rdy=%b%b req S%0d id=%h addr=%h len=%h",
                   k, ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARREADY_M1, ARREADY_M0,
                   sidx, {(mst ? 4'b0010 : 4'b0001), id}, addr, len);
        end
        step();
      end
      ARREADY_S = '0;
    end
    sp = 0; mp = 0; cyc = 0;
    while (mp <= int'(len) && mp != abort_at) begin
      if (cyc > 300) begin
        failures++;
        $display("FAIL timeout: %0d of %0d beats delivered", mp, int'(len) + 1);
        break;
      end
      RLAST_S = 6'($urandom);
      RVALID_S = 6'($urandom);
      for (int s = 0; s < 6; s++) begin
        RDATA_S[s*32 +: 32] = $urandom;
        RID_S[s*8 +: 8] = 8'($urandom);
        RRESP_S[s*2 +: 2] = 2'($urandom);
      end
      if (tgt != 3'd7) begin
        rv = ($urandom_range(0, 3) != 0);
        RVALID_S[sidx] = rv;
        RDATA_S[sidx*32 +: 32] = data[sp];
        RID_S[sidx*8 +: 8] = {(mst ? 4'b0010 : 4'b0001), id};
        RRESP_S[sidx*2 +: 2] = rsp[sp];
        RLAST_S[sidx] = (sp == bad_beat) || (sp == int'(len));
      end
      rr = use_pat ? ((cyc < 16) ? rr_pat[cyc] : 1'b1) : ($urandom_range(0, 2) != 0);
      if (mst) begin RREADY_M1 = rr; RREADY_M0 = 1'($urandom); end
      else     begin RREADY_M0 = rr; RREADY_M1 = 1'($urandom); end
      #1;
      exp_rs = '0;
      if (tgt != 3'd7 && (sp == mp || rr) && sp <= int'(len)) exp_rs[sidx] = 1'b1;
      checks++;
      if (RREADY_S !== exp_rs) begin
        failures++;
        $display("FAIL rready_s cyc%0d: RREADY_S=%b required %b", cyc, RREADY_S, exp_rs);
      end
      mv = mst ? RVALID_M1 : RVALID_M0;
      md = mst ? RDATA_M1 : RDATA_M0;
      mi = mst ? RID_M1 : RID_M0;
      mr = mst ? RRESP_M1 : RRESP_M0;
      ml = mst ? RLAST_M1 : RLAST_M0;
      ov = mst ? (RVALID_M0 || RLAST_M0 || |RDATA_M0 || |RID_M0 || |RRESP_M0)
               : (RVALID_M1 || RLAST_M1 || |RDATA_M1 || |RID_M1 || |RRESP_M1);
      checks++;
      if (ov || ARVALID_S !== 6'b0 || ARREADY_M0 !== 1'b0 || ARREADY_M1 !== 1'b0) begin
        failures++;
        $display("FAIL quiet_outputs cyc%0d: other_master_active=%b ARVALID_S=%b ARREADY=%b%b required all 0",
                 cyc, ov, ARVALID_S, ARREADY_M1, ARREADY_M0);
      end
      if (tgt != 3'd7) begin
        checks++;
        if (mv !== (sp > mp)) begin
          failures++;
          $display("FAIL rvalid_m cyc%0d: RVALID=%b required %b", cyc, mv, sp > mp);
        end
      end
      if (mv && rr) begin
        checks++;
        if (tgt == 3'd7 ? (md !== 32'h0 || mr !== 2'b11)
                        : (md !== data[mp] || mr !== rsp[mp]) ||
            mi !== id || ml !== (mp == int'(len))) begin
          failures++;
          $display("FAIL r_beat%0d: data=%h resp=%b id=%h last=%b required data=%h resp=%b id=%h last=%b",
                   mp, md, mr, mi, ml, (tgt == 3'd7) ? 32'h0 : data[mp],
                   (tgt == 3'd7) ? 2'b11 : rsp[mp], id, mp == int'(len));
        end
        mp++;
      end
      if (tgt != 3'd7 && RVALID_S[sidx] && RREADY_S[sidx] && sp < 16) sp++;
      step();
      cyc++;
    end
    if (abort_at < 0) clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESETn = 1'b0;
    step(); step();
    checks++;
    if ({ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1, RLAST_M0, RLAST_M1, proto_err} !== 7'b0 ||
        {RDATA_M0, RDATA_M1, RID_M0, RID_M1, RRESP_M0, RRESP_M1} !== '0 ||
        {ARVALID_S, RREADY_S, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} !== '0) begin
      failures++;
      $display("FAIL reset_state: ARVALID_S=%b RREADY_S=%b RVALID=%b%b proto_err=%b required all 0",
               ARVALID_S, RREADY_S, RVALID_M1, RVALID_M0, proto_err);
    end
    ARESETn = 1'b1;
    step();
  endtask

  task automatic test_single_rom();
    AR_arbiter = 4'b0010;
    ARID_M0 = 4'h5; ARADDR_M0 = 32'h0000_0040; ARLEN_M0 = 4'd0; ARSIZE_M0 = 3'd2;
    ARBURST_M0 = 2'b01; ARVALID_M0 = 1'b1;
    #1;
    checks++;
    if (ARREADY_M0 !== 1'b1 || ARREADY_M1 !== 1'b0) begin
      failures++;
      $display("FAIL rom_arready: M0=%b M1=%b required 1 0", ARREADY_M0, ARREADY_M1);
    end
    step();
    clear_inputs();
    ARREADY_S = 6'b000001;
    #1;
    checks++;
    if (ARVALID_S !== 6'b000001 || ARID_S !== 8'h15 || ARADDR_S !== 32'h40) begin
      failures++;
      $display("FAIL rom_ar: ARVALID_S=%b ARID_S=%h ARADDR_S=%h required 000001 15 00000040",
               ARVALID_S, ARID_S, ARADDR_S);
    end
    step();
    ARREADY_S = '0;
    RVALID_S = 6'b000001; RDATA_S[31:0] = 32'hDEAD_BEEF; RLAST_S = 6'b000001;
    RID_S[7:0] = 8'h15; RREADY_M0 = 1'b1;
    #1;
    checks++;
    if (RREADY_S !== 6'b000001 || RVALID_M0 !== 1'b0) begin
      failures++;
      $display("FAIL rom_rready: RREADY_S=%b RVALID_M0=%b required 000001 0", RREADY_S, RVALID_M0);
    end
    step();
    RVALID_S = '0;
    #1;
    checks++;
    if (RVALID_M0 !== 1'b1 || RDATA_M0 !== 32'hDEAD_BEEF || RLAST_M0 !== 1'b1 ||
        RRESP_M0 !== 2'b00 || RID_M0 !== 4'h5) begin
      failures++;
      $display("FAIL rom_beat: valid=%b data=%h last=%b resp=%b id=%h required 1 deadbeef 1 00 5",
               RVALID_M0, RDATA_M0, RLAST_M0, RRESP_M0, RID_M0);
    end
    step();
    checks++;
    if (RVALID_M0 !== 1'b0 || RREADY_S !== 6'b0 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL rom_done: RVALID_M0=%b RREADY_S=%b proto_err=%b required 0 0 0",
               RVALID_M0, RREADY_S, proto_err);
    end
    clear_inputs();
  endtask

  task automatic test_dram_backpressure();
    run_txn(1'b1, 3'd6, 4'd3, 0, -1, 1'b1, 16'b0000_0000_0010_1101, -1, 32'h8000_1000);
  endtask

  task automatic test_unmapped();
    run_txn(1'b1, 3'd7, 4'd1, 0, -1, 1'b0, 16'h0, -1, 32'h3000_0000);
    run_txn(1'b0, 3'd7, 4'd4, 0, -1, 1'b0, 16'h0, -1, 32'h3000_0100);
  endtask

  task automatic test_addr_stall();
    run_txn(1'b0, 3'd3, 4'd2, 5, -1, 1'b0, 16'h0, -1, 32'h2000_0080);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 25; n++) begin
      run_txn(1'($urandom), 3'($urandom_range(1, 7)), 4'($urandom), $urandom_range(0, 3), -1,
              1'b0, 16'h0, -1, $urandom);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL proto_err_clean: proto_err=%b required 0", proto_err);
    end
  endtask

  task automatic test_proto_err();
    run_txn(1'b0, 3'd2, 4'd2, 0, 1, 1'b0, 16'h0, -1, 32'h1000_0000);
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_err_set: proto_err=%b required 1", proto_err);
    end
    run_txn(1'b1, 3'd4, 4'd1, 1, -1, 1'b0, 16'h0, -1, 32'h4000_0000);
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_err_sticky: proto_err=%b required 1", proto_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    run_txn(1'b0, 3'd6, 4'd3, 0, -1, 1'b1, 16'hFFFF, 1, 32'h8000_2000);
    ARESETn = 1'b0;
    AR_arbiter = '0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
    RVALID_S = 6'b100000;
    step();
    ARESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({RVALID_M0, RVALID_M1, RLAST_M0, proto_err} !== 4'b0 || RDATA_M0 !== '0 ||
          RID_M0 !== '0 || ARVALID_S !== '0 || RREADY_S !== '0) begin
        failures++;
        $display("FAIL reset_abort cyc%0d: RVALID=%b%b RDATA_M0=%h RREADY_S=%b proto_err=%b required 0",
                 k, RVALID_M1, RVALID_M0, RDATA_M0, RREADY_S, proto_err);
      end
      step();
    end
    clear_inputs();
    run_txn(1'b0, 3'd6, 4'd3, 1, -1, 1'b0, 16'h0, -1, 32'h8000_3000);
  endtask

  initial begin
    test_reset();
    test_single_rom();
    test_dram_backpressure();
    test_unmapped();
    test_addr_stall();
    test_back_to_back();
    test_proto_err();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
